// File: rtl/clusterv_banked_sram_ctrl.sv
// clusterv_banked_sram_ctrl: Wishbone target over banked single-port SRAM with byte enables
module clusterv_banked_sram_ctrl #(
  parameter int DAT_WIDTH      = 32,
  parameter int ADR_WIDTH      = 32,
  parameter int N_BANKS        = 4,
  parameter int BANK_ADR_WIDTH = 10,
  parameter int WINDOW_WIDTH   = 16,
  parameter int INTERLEAVE     = 0,
  parameter int RD_LATENCY     = 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [ADR_WIDTH-1:0]                t_adr,
  input  logic [DAT_WIDTH-1:0]                t_dat_w,
  output logic [DAT_WIDTH-1:0]                t_dat_r,
  input  logic                                t_cyc,
  input  logic                                t_stb,
  input  logic                                t_we,
  input  logic [DAT_WIDTH/8-1:0]              t_sel,
  output logic                                t_ack,
  output logic                                t_err,
  output logic [N_BANKS*BANK_ADR_WIDTH-1:0]   m_addr,
  output logic [N_BANKS*DAT_WIDTH-1:0]        m_write_data,
  input  logic [N_BANKS*DAT_WIDTH-1:0]        m_read_data,
  output logic [N_BANKS-1:0]                  m_write_en,
  output logic [N_BANKS-1:0]                  m_read_en,
  output logic [N_BANKS*DAT_WIDTH/8-1:0]      m_byte_en
);
  localparam int SW  = DAT_WIDTH / 8;
  localparam int OFS = $clog2(SW);
  localparam int BB  = $clog2(N_BANKS);
  localparam int BW  = BB > 0 ? BB : 1;
  localparam int WAW = WINDOW_WIDTH - OFS;
  localparam int BEW = N_BANKS * SW;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [BW-1:0] bank, bank_q, bank_n;
  logic abort, abort_n, ack_n, err_n;
  logic [DAT_WIDTH-1:0] dat_n;
  logic [WAW-1:0] wa, wa_hi, wa_lo, wa_top;
  logic [BANK_ADR_WIDTH-1:0] baddr;
  logic req, oor, go;
  logic unused_ok;

  assign wa     = t_adr[WINDOW_WIDTH-1:OFS];
  assign wa_hi  = wa >> BANK_ADR_WIDTH;
  assign wa_lo  = wa >> BB;
  assign wa_top = wa >> (BB + BANK_ADR_WIDTH);
  assign bank   = (INTERLEAVE != 0 ? wa[BW-1:0] : wa_hi[BW-1:0]) & BW'(N_BANKS - 1);
  assign baddr  = INTERLEAVE != 0 ? wa_lo[BANK_ADR_WIDTH-1:0] : wa[BANK_ADR_WIDTH-1:0];
  assign oor    = |wa_top;
  assign req    = t_cyc & t_stb;
  assign go     = reset_n & req & ~oor & (state == IDLE);
  assign unused_ok = ^{t_adr, wa_hi, wa_lo};

  assign m_addr       = {N_BANKS{baddr}};
  assign m_write_data = {N_BANKS{t_dat_w}};
  assign m_write_en   = (go & t_we & |t_sel) ? N_BANKS'(1) << bank : '0;
  assign m_read_en    = (go & ~t_we) ? N_BANKS'(1) << bank : '0;
  assign m_byte_en    = (go & t_we) ? BEW'(t_sel) << (bank * SW) : '0;

  // next state, read-latency countdown, read capture and response generation
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bank_n  = bank_q;
    abort_n = abort;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    dat_n   = t_dat_r;
    case (state)
      IDLE: if (req) begin
        abort_n = 1'b0;
        if (oor) begin
          err_n   = 1'b1;
          state_n = RESP;
        end else if (t_we) begin
          ack_n   = 1'b1;
          state_n = RESP;
        end else begin
          bank_n  = bank;
          cnt_n   = 2'(RD_LATENCY - 1);
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        abort_n = abort | ~t_cyc;
        cnt_n   = cnt - 2'd1;
        if (cnt == 2'd0) begin
          dat_n   = m_read_data[bank_q*DAT_WIDTH +: DAT_WIDTH];
          ack_n   = t_cyc & ~abort;
          cnt_n   = 2'd0;
          state_n = RESP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and registered bus responses; reset cancels any operation in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bank_q  <= '0;
      abort   <= 1'b0;
      t_ack   <= 1'b0;
      t_err   <= 1'b0;
      t_dat_r <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bank_q  <= bank_n;
      abort   <= abort_n;
      t_ack   <= ack_n;
      t_err   <= err_n;
      t_dat_r <= dat_n;
    end
  end
endmodule
